// File: rtl/int_gen_responder.sv
// External interrupt source for the CPU top's interrupt/m_int_* interface.
// Raises a level request on a delay counter or a PC match; the handler acks by store.
module int_gen_responder #(
    parameter logic [31:0] ACK_ADDR    = 32'h0000_7F20,
    parameter logic [15:0] FIRST_DELAY = 16'd200,
    parameter logic [15:0] PERIOD      = 16'd500,
    parameter logic [31:0] TRIG_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [15:0] int_count,
    output logic        spurious_ack,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        ASSERT = 2'b01,
        DONE   = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic        spur_q, spur_d;
    logic        match_q;

    logic ack;
    logic match;
    logic pc_fire;
    logic cnt_fire;
    logic unused_addr_lsbs;

    // Acknowledge is word-granular: the low address bits only select bytes.
    assign ack = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (|m_int_byteen);

    assign unused_addr_lsbs = ^m_int_addr[1:0];

    // A PC trigger fires on arrival at TRIG_PC, so a stalled PC fires once.
    assign match    = (TRIG_PC != 32'd0) && (macroscopic_pc == TRIG_PC);
    assign pc_fire  = match && !match_q;
    assign cnt_fire = (cnt_q == 16'd0);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        irq_d   = irq_q;
        spur_d  = spur_q;
        unique case (state_q)
            ARMED: begin
                irq_d = 1'b0;
                if (!cnt_fire) begin
                    cnt_d = cnt_q - 16'd1;
                end
                // An ack here is never applied to a request raised this cycle.
                if (ack) begin
                    spur_d = 1'b1;
                end
                if (cnt_fire || pc_fire) begin
                    state_d = ASSERT;
                    irq_d   = 1'b1;
                end
            end
            ASSERT: begin
                irq_d = 1'b1;
                if (ack) begin
                    irq_d = 1'b0;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (PERIOD != 16'd0) begin
                        cnt_d   = PERIOD;
                        state_d = ARMED;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                irq_d = 1'b0;
                if (ack) begin
                    spur_d = 1'b1;
                end
            end
            default: begin
                state_d = ARMED;
                irq_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
            cnt_q   <= FIRST_DELAY;
            count_q <= 16'd0;
            irq_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            irq_q   <= irq_d;
            spur_q  <= spur_d;
        end
    end

    // Previous-cycle PC match, tracked in every state for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    assign interrupt    = irq_q;
    assign int_count    = count_q;
    assign spurious_ack = spur_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_int_gen_responder.sv
// Directed bench for int_gen_responder.
// Three instances cover one-shot, periodic and PC-trigger configurations.
module tb_int_gen_responder;

    logic clk;
    int   tests;
    int   fails;

    logic        rst0, rst1, rst2;
    logic [31:0] pc0, pc1, pc2;
    logic [31:0] addr0, addr1, addr2;
    logic [3:0]  be0, be1, be2;
    logic        irq0, irq1, irq2;
    logic [15:0] cnt0, cnt1, cnt2;
    logic        sp0, sp1, sp2;
    logic [1:0]  st0, st1, st2;

    int_gen_responder #(
        .ACK_ADDR(32'h0000_7F20), .FIRST_DELAY(16'd10),
        .PERIOD(16'd0), .TRIG_PC(32'h0)
    ) u0 (
        .clk(clk), .reset(rst0), .macroscopic_pc(pc0),
        .m_int_addr(addr0), .m_int_byteen(be0),
        .interrupt(irq0), .int_count(cnt0),
        .spurious_ack(sp0), .state_o(st0)
    );

    int_gen_responder #(
        .ACK_ADDR(32'h0000_7F20), .FIRST_DELAY(16'd5),
        .PERIOD(16'd20), .TRIG_PC(32'h0)
    ) u1 (
        .clk(clk), .reset(rst1), .macroscopic_pc(pc1),
        .m_int_addr(addr1), .m_int_byteen(be1),
        .interrupt(irq1), .int_count(cnt1),
        .spurious_ack(sp1), .state_o(st1)
    );

    int_gen_responder #(
        .ACK_ADDR(32'h0000_7F20), .FIRST_DELAY(16'hFFFF),
        .PERIOD(16'd1000), .TRIG_PC(32'h0000_3008)
    ) u2 (
        .clk(clk), .reset(rst2), .macroscopic_pc(pc2),
        .m_int_addr(addr2), .m_int_byteen(be2),
        .interrupt(irq2), .int_count(cnt2),
        .spurious_ack(sp2), .state_o(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Edges counted until u1 raises its request, bounded.
    task automatic wait_rise1(input int exp, input string tag);
        int n;
        n = 0;
        while (irq1 !== 1'b1 && n < 300) begin
            step(1);
            n++;
        end
        check(tag, n, exp);
    endtask

    // One sw to the ack word on u1, sampled at the next edge.
    task automatic ack1();
        addr1 = 32'h0000_7F20;
        be1   = 4'b1111;
        step(1);
        be1   = 4'b0000;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        pc0 = 32'h0; pc1 = 32'h0; pc2 = 32'h0;
        addr0 = 32'h0; addr1 = 32'h0; addr2 = 32'h0;
        be0 = 4'h0; be1 = 4'h0; be2 = 4'h0;
        step(3);

        check("rst_irq", irq0, 1'b0);
        check("rst_cnt", cnt0, 16'd0);
        check("rst_spur", sp0, 1'b0);
        check("rst_state", st0, 2'b00);

        // One-shot counter trigger, byte-store ack.
        rst0 = 1'b0;
        step(10);
        check("a_irq_e10", irq0, 1'b0);
        step(1);
        check("a_irq_e11", irq0, 1'b1);
        check("a_state_assert", st0, 2'b01);
        step(2);
        check("a_irq_hold", irq0, 1'b1);
        addr0 = 32'h0000_7F21;
        be0   = 4'b0010;
        step(1);
        be0   = 4'b0000;
        check("a_irq_fall", irq0, 1'b0);
        check("a_count", cnt0, 16'd1);
        check("a_state_done", st0, 2'b10);
        check("a_spur0", sp0, 1'b0);
        step(5);
        check("a_done_quiet", irq0, 1'b0);
        addr0 = 32'h0000_7F20;
        be0   = 4'b1111;
        step(1);
        be0   = 4'b0000;
        check("a_done_spur", sp0, 1'b1);
        check("a_done_irq", irq0, 1'b0);
        check("a_done_state", st0, 2'b10);
        check("a_done_count", cnt0, 16'd1);

        // Periodic re-arm, spurious ack in ARMED, reset mid-ASSERT.
        rst1 = 1'b0;
        wait_rise1(6, "b_rise1");
        step(2);
        ack1();
        check("b_fall1", irq1, 1'b0);
        check("b_count1", cnt1, 16'd1);
        check("b_armed1", st1, 2'b00);
        step(13);
        ack1();
        check("b_spur", sp1, 1'b1);
        check("b_spur_irq", irq1, 1'b0);
        check("b_spur_state", st1, 2'b00);
        check("b_spur_count", cnt1, 16'd1);
        wait_rise1(7, "b_rise2");
        step(2);
        ack1();
        check("b_count2", cnt1, 16'd2);
        wait_rise1(21, "b_rise3");

        addr1 = 32'h0000_7F24;
        be1   = 4'b1111;
        step(1);
        check("b_other_irq", irq1, 1'b1);
        check("b_other_count", cnt1, 16'd2);
        addr1 = 32'h0000_7F20;
        be1   = 4'b0000;
        step(1);
        check("b_nobe_irq", irq1, 1'b1);
        check("b_nobe_count", cnt1, 16'd2);

        rst1 = 1'b1;
        step(1);
        rst1 = 1'b0;
        check("b_rst_irq", irq1, 1'b0);
        check("b_rst_count", cnt1, 16'd0);
        check("b_rst_spur", sp1, 1'b0);
        check("b_rst_state", st1, 2'b00);
        wait_rise1(6, "b_rise_rst");
        step(2);
        ack1();
        check("b_count_rst", cnt1, 16'd1);

        // Ack in the same cycle the counter reaches zero.
        step(20);
        ack1();
        check("c_coll_irq", irq1, 1'b1);
        check("c_coll_state", st1, 2'b01);
        check("c_coll_spur", sp1, 1'b1);
        check("c_coll_count", cnt1, 16'd1);
        step(3);
        check("c_coll_hold", irq1, 1'b1);
        ack1();
        check("c_coll_fall", irq1, 1'b0);
        check("c_coll_count2", cnt1, 16'd2);

        // PC trigger with a stalled PC.
        rst2 = 1'b0;
        step(3);
        check("p_idle", irq2, 1'b0);
        pc2 = 32'h0000_3008;
        step(1);
        check("p_fire", irq2, 1'b1);
        step(4);
        check("p_hold", irq2, 1'b1);
        check("p_hold_state", st2, 2'b01);
        addr2 = 32'h0000_7F20;
        be2   = 4'b1111;
        step(1);
        be2   = 4'b0000;
        check("p_fall", irq2, 1'b0);
        check("p_count", cnt2, 16'd1);
        step(5);
        check("p_no_refire", irq2, 1'b0);
        check("p_armed", st2, 2'b00);
        pc2 = 32'h0000_3000;
        step(1);
        check("p_away", irq2, 1'b0);
        pc2 = 32'h0000_3008;
        step(1);
        check("p_refire", irq2, 1'b1);
        check("p_spur", sp2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/int_gen_responder.md
Name: int_gen_responder

Overview:
- Models the external interrupt source on the far side of the CPU top's `interrupt` / `m_int_addr` / `m_int_byteen` interface.
- Raises a level interrupt request, either after a programmable cycle delay or when the committed (macroscopic) PC matches a trigger address.
- Holds the request until the CPU handler acknowledges it with a store to the acknowledge address, then re-arms, or stops in one-shot mode.
- Instantiated beside the CPU top in the system testbench and SoC wrapper.

Parameters:
- ACK_ADDR, 32'h0000_7F20: word address the handler stores to as acknowledge; bits [1:0] are ignored.
- FIRST_DELAY, 16'd200: cycles after reset before the first counter trigger.
- PERIOD, 16'd500: reload value after each acknowledge; 0 means one-shot (enter DONE after first ack).
- TRIG_PC, 32'h0000_0000: PC-match trigger address; 0 disables PC matching.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- macroscopic_pc  in  32  committed (M-stage) PC from the CPU top
- m_int_addr  in  32  store address seen by the interrupt source
- m_int_byteen  in  4  store byte enables; any bit set means a store this cycle
- interrupt  out  1  interrupt request, registered, level
- int_count  out  16  number of acknowledged interrupts, saturates at 16'hFFFF
- spurious_ack  out  1  sticky flag: an acknowledge arrived while not in ASSERT
- state_o  out  2  current state (00 ARMED, 01 ASSERT, 10 DONE) for debug

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - Outputs: interrupt=0, int_count=0, spurious_ack=0, state=ARMED.
  - Internals: cnt=FIRST_DELAY, match_q=0.
- Definitions:
  - ack = (m_int_addr[31:2]==ACK_ADDR[31:2]) && (|m_int_byteen).
  - match = (TRIG_PC!=0) && (macroscopic_pc==TRIG_PC).
  - match_q = match registered every cycle. A PC trigger fires only on match && !match_q, so a stalled PC fires once.
- ARMED:
  - cnt decrements by 1 per cycle while nonzero.
  - Trigger when (cnt==0) or (match && !match_q); next state is ASSERT and interrupt=1 from the following edge.
  - Latency: trigger condition true in cycle N -> interrupt high in cycle N+1.
  - FIRST_DELAY=0 therefore asserts interrupt in the first cycle after reset deasserts.
- ASSERT:
  - interrupt held at 1; cnt frozen; PC matches ignored (match_q still tracks).
  - On ack in cycle N: interrupt=0 in cycle N+1 and int_count increments (saturating).
  - If PERIOD!=0: cnt=PERIOD and next state is ARMED.
  - If PERIOD==0: next state is DONE.
- DONE:
  - interrupt stays 0; only reset leaves DONE.
  - ack in DONE sets spurious_ack.
- Spurious acknowledge:
  - ack in ARMED or DONE sets spurious_ack (sticky until reset) and has no other effect.
  - ack and trigger in the same ARMED cycle: the trigger is taken (ASSERT) and spurious_ack is set; the ack is not applied to the new request.
- Multiple stores: multiple ack stores in consecutive ASSERT cycles give one acknowledge. The first leaves ASSERT; the following ones land in ARMED/DONE and are spurious.
- Partial writes: byte or half-word stores to the ack word count as ack (any byteen bit set).
- Non-ack traffic: stores to any other address are ignored.
- Reset mid-operation: reset while in ASSERT drops interrupt in the next cycle and clears the count. The pending request is lost, not replayed.
- Counter width: 16 bits, no wrap. It only counts down to 0 and stops.
- Output timing: all outputs come straight from registers; no combinational path from inputs to outputs.

Test Plan:
- Counter trigger with ack:
  - Stimulus: FIRST_DELAY=10, PERIOD=0, TRIG_PC=0; release reset; sb to 0x7F21 (byteen=4'b0010) 3 cycles after interrupt rises.
  - Required: interrupt rises exactly 11 cycles after reset release (cnt reaches 0 after 10 decrements, output registered); falls the cycle after the ack; int_count=1; state=DONE; spurious_ack=0.
- Periodic re-arm:
  - Stimulus: FIRST_DELAY=5, PERIOD=20; ack each request 2 cycles after it rises.
  - Required: rising edges spaced 20+1+3 cycles apart; int_count=3 after the third ack.
- PC trigger on stalled PC:
  - Stimulus: TRIG_PC=32'h3008, FIRST_DELAY=16'hFFFF; hold macroscopic_pc=32'h3008 for 5 cycles, then ack.
  - Required: exactly one assertion; after the ack, still no re-trigger while PC stays 32'h3008; re-fires only after PC leaves and returns.
- Spurious and collision ack:
  - Stimulus: sw to 0x7F20 in ARMED with cnt=7.
  - Required: spurious_ack=1, cnt keeps counting, no interrupt change.
  - Stimulus: ack in the same cycle cnt hits 0.
  - Required: interrupt rises next cycle and stays high until a later ack.
- Non-ack traffic:
  - Stimulus: sw to 0x7F24, and a store to 0x7F20 with byteen=0, during ASSERT.
  - Required: interrupt stays 1, int_count unchanged.
- Reset mid-ASSERT:
  - Stimulus: assert reset for 1 cycle while interrupt=1 and int_count=2.
  - Required: next cycle interrupt=0, int_count=0, spurious_ack=0, state=ARMED; request re-raises FIRST_DELAY+1 cycles after reset drops.
